// File: rtl/kvt_scfifo_pkg.sv
// Shared types and helpers for the scfifo read-drain block.
package kvt_scfifo_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

  localparam int unsigned RD_LAT_MAX = 2;
  localparam int unsigned DW_DEF     = 8;

  // Ceiling log2, never below 1 so a counter or pointer always has at least one bit.
  function automatic int unsigned clog2_sat(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/kvt_skid_buf.sv
// Small register FIFO that absorbs words returning from the scfifo while the consumer stalls.
module kvt_skid_buf
  import kvt_scfifo_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned OccW = clog2_sat(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            wr_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            rd_i,
  input  logic            clr_i,
  output logic [OccW-1:0] occ_o,
  output logic [DW-1:0]   head_o
);

  localparam int unsigned PtrW = clog2_sat(DEPTH);

  logic [DW-1:0]   mem_q [DEPTH];
  logic [DW-1:0]   mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0] occ_q, occ_d;
  logic            do_rd;

  // Depth need not be a power of two, so wrap explicitly.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_rd  = rd_i && (occ_q != '0);
  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_ptr_q];

  // Next-state: clear wins over write/read; write and read may coincide at any occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (wr_i) begin
        mem_d[wr_ptr_q] = wr_data_i;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
      occ_d = occ_q + OccW'(wr_i) - OccW'(do_rd);
    end
  end

  // Storage, pointers and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_i && !clr_i && !rd_i && (occ_q == OccW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_i && !clr_i && (occ_q == '0)));
`endif

endmodule

// File: rtl/kvt_scfifo_rd_drain.sv
// Read-side master for an scfifo: issues reads, captures returning data, re-streams it.
module kvt_scfifo_rd_drain
  import kvt_scfifo_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = 1  // 1..RD_LAT_MAX
) (
  input  logic          clk,
  input  logic          rst,
  output logic          rd_en_o,
  input  logic [DW-1:0] rd_data_i,
  input  logic          empty_i,
  output logic          m_valid_o,
  output logic [DW-1:0] m_data_o,
  input  logic          m_ready_i,
  input  logic          flush_i,
  output logic [1:0]    level_o,
  output logic          busy_o
);

  localparam int unsigned SKID = RD_LAT + 1;
  localparam int unsigned CntW = clog2_sat(SKID + 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   inflight_q, inflight_d;
  logic [RD_LAT-1:0] flag_q, flag_d;
  logic [CntW-1:0]   occ;
  logic [CntW-1:0]   level;
  logic [CntW:0]     committed;
  logic              pop, cap, wr;

  assign pop       = m_valid_o && m_ready_i;
  assign cap       = flag_q[RD_LAT-1];
  // Slots already claimed once this cycle's pop retires; a capture moves a word
  // from inflight to occ and leaves the sum unchanged.
  assign committed = {1'b0, inflight_q} + {1'b0, occ} - {{CntW{1'b0}}, pop};
  // No issue in the flush cycle: that word would be dropped on return anyway.
  assign rd_en_o   = (state_q == StRun) && !flush_i && !empty_i &&
                     (committed < (CntW + 1)'(SKID));
  assign wr        = cap && (state_q != StFlush) && !flush_i;
  assign m_valid_o = (occ != '0);
  assign level     = inflight_q + occ;
  assign level_o   = 2'(level);
  assign busy_o    = (state_q != StIdle);

  // FSM, inflight counter and read-latency delay line next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = StRun;
      StRun:   if (flush_i) state_d = StFlush;
      StFlush: if ((inflight_q == '0) && !flush_i) state_d = StRun;
      default: state_d = StIdle;
    endcase
    inflight_d = inflight_q + CntW'(rd_en_o) - CntW'(cap);
    flag_d     = '0;
    flag_d[0]  = rd_en_o;
    for (int i = 1; i < RD_LAT; i++) flag_d[i] = flag_q[i-1];
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      inflight_q <= '0;
      flag_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      flag_q     <= flag_d;
    end
  end

  kvt_skid_buf #(
    .DW    (DW),
    .DEPTH (SKID)
  ) u_skid (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_i      (wr),
    .wr_data_i (rd_data_i),
    .rd_i      (pop),
    .clr_i     (flush_i),
    .occ_o     (occ),
    .head_o    (m_data_o)
  );

`ifndef SYNTHESIS
  a_inflight_range: assert property (@(posedge clk) disable iff (!rst)
    inflight_q <= CntW'(RD_LAT));
  a_occ_range: assert property (@(posedge clk) disable iff (!rst)
    occ <= CntW'(SKID));
  a_level_range: assert property (@(posedge clk) disable iff (!rst)
    level <= CntW'(SKID));
  a_inflight_underflow: assert property (@(posedge clk) disable iff (!rst)
    !(cap && (inflight_q == '0)));
  a_inflight_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(rd_en_o && !cap && (inflight_q == CntW'(RD_LAT))));
`endif

endmodule

// File: tb/tb_kvt_scfifo_rd_drain.sv
// Directed bench: two DUT builds (RD_LAT=1 and RD_LAT=2), each fed by a behavioural scfifo.
module tb_kvt_scfifo_rd_drain;

  logic       clk;
  logic       rst;
  // RD_LAT=1 instance
  logic       rd_en1, empty1, valid1, ready1, flush1, busy1;
  logic [7:0] rd_data1, data1;
  logic [1:0] level1;
  // RD_LAT=2 instance
  logic       rd_en2, empty2, valid2, ready2, flush2, busy2;
  logic [7:0] rd_data2, data2, stage2;
  logic [1:0] level2;

  logic [7:0] mem1 [2048];
  logic [7:0] mem2 [2048];
  int         wp1 = 0, rp1 = 0, wp2 = 0, rp2 = 0;
  logic [7:0] out1 [4096];
  logic [7:0] out2 [256];
  int         nout1 = 0, nout2 = 0;
  int         checks = 0, errors = 0;

  kvt_scfifo_rd_drain #(.DW(8), .RD_LAT(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .rd_en_o   (rd_en1),
    .rd_data_i (rd_data1),
    .empty_i   (empty1),
    .m_valid_o (valid1),
    .m_data_o  (data1),
    .m_ready_i (ready1),
    .flush_i   (flush1),
    .level_o   (level1),
    .busy_o    (busy1)
  );

  kvt_scfifo_rd_drain #(.DW(8), .RD_LAT(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .rd_en_o   (rd_en2),
    .rd_data_i (rd_data2),
    .empty_i   (empty2),
    .m_valid_o (valid2),
    .m_data_o  (data2),
    .m_ready_i (ready2),
    .flush_i   (flush2),
    .level_o   (level2),
    .busy_o    (busy2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural scfifos; reset drops everything not yet read.
  assign empty1 = (rp1 == wp1);
  assign empty2 = (rp2 == wp2);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp1      <= wp1;
      rd_data1 <= 8'h00;
    end else if (rd_en1) begin
      rd_data1 <= mem1[rp1];
      rp1      <= rp1 + 1;
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp2      <= wp2;
      stage2   <= 8'h00;
      rd_data2 <= 8'h00;
    end else begin
      rd_data2 <= stage2;
      if (rd_en2) begin
        stage2 <= mem2[rp2];
        rp2    <= rp2 + 1;
      end
    end
  end

  // Stream transfer recorders.
  always @(posedge clk) begin
    if (valid1 && ready1) begin
      out1[nout1] <= data1;
      nout1       <= nout1 + 1;
    end
    if (valid2 && ready2) begin
      out2[nout2] <= data2;
      nout2       <= nout2 + 1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push1(input logic [7:0] v);
    mem1[wp1] = v;
    wp1 = wp1 + 1;
  endtask

  task automatic push2(input logic [7:0] v);
    mem2[wp2] = v;
    wp2 = wp2 + 1;
  endtask

  // Assert reset across two edges, release on a negedge; the next negedge is cycle N0.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_words1(input int target, input string name);
    int k;
    k = 0;
    while (nout1 < target && k < 40) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (nout1 < target) begin
      errors++;
      $display("FAIL %s timeout: words %0d required %0d", name, nout1, target);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks += 7;
    if (rd_en1 !== 1'b0) begin errors++; $display("FAIL rst_rd_en got %b exp 0", rd_en1); end
    if (valid1 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", valid1); end
    if (data1 !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", data1); end
    if (level1 !== 2'd0) begin errors++; $display("FAIL rst_level got %0d exp 0", level1); end
    if (busy1 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy1); end
    if (rd_en2 !== 1'b0) begin errors++; $display("FAIL rst_rd_en2 got %b exp 0", rd_en2); end
    if (busy2 !== 1'b0) begin errors++; $display("FAIL rst_busy2 got %b exp 0", busy2); end
  endtask

  task automatic test_stream();
    bit         e_rd [7];
    bit         e_vl [7];
    logic [1:0] e_lv [7];
    logic [7:0] e_dt [7];
    e_rd = '{1, 1, 1, 1, 0, 0, 0};
    e_vl = '{0, 0, 1, 1, 1, 1, 0};
    e_lv = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd1, 2'd0};
    e_dt = '{8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    ready1 = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) push1(8'(8'h11 + i));
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checks += 3;
      if (rd_en1 !== e_rd[c]) begin errors++; $display("FAIL t1_rd_en cyc %0d got %b exp %b", c, rd_en1, e_rd[c]); end
      if (valid1 !== e_vl[c]) begin errors++; $display("FAIL t1_valid cyc %0d got %b exp %b", c, valid1, e_vl[c]); end
      if (level1 !== e_lv[c]) begin errors++; $display("FAIL t1_level cyc %0d got %0d exp %0d", c, level1, e_lv[c]); end
      if (e_vl[c]) begin
        checks++;
        if (data1 !== e_dt[c]) begin errors++; $display("FAIL t1_data cyc %0d got %h exp %h", c, data1, e_dt[c]); end
      end
      if (c == 0) begin
        checks++;
        if (busy1 !== 1'b1) begin errors++; $display("FAIL t1_busy got %b exp 1", busy1); end
      end
    end
  endtask

  task automatic test_stall();
    bit         e_rd [6];
    bit         e_vl [6];
    logic [1:0] e_lv [6];
    int         s;
    e_rd = '{1, 1, 0, 0, 0, 0};
    e_vl = '{0, 0, 1, 1, 1, 1};
    e_lv = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2};
    ready1 = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) push1(8'(8'h11 + i));
    s = nout1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks += 3;
      if (rd_en1 !== e_rd[c]) begin errors++; $display("FAIL t2_rd_en cyc %0d got %b exp %b", c, rd_en1, e_rd[c]); end
      if (valid1 !== e_vl[c]) begin errors++; $display("FAIL t2_valid cyc %0d got %b exp %b", c, valid1, e_vl[c]); end
      if (level1 !== e_lv[c]) begin errors++; $display("FAIL t2_level cyc %0d got %0d exp %0d", c, level1, e_lv[c]); end
      if (e_vl[c]) begin
        checks++;
        if (data1 !== 8'h11) begin errors++; $display("FAIL t2_hold cyc %0d got %h exp 11", c, data1); end
      end
    end
    ready1 = 1'b1;
    wait_words1(s + 4, "t2_drain");
    repeat (3) @(negedge clk);
    checks++;
    if (nout1 - s !== 4) begin errors++; $display("FAIL t2_count got %0d exp 4", nout1 - s); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out1[s+i] !== 8'(8'h11 + i)) begin
        errors++; $display("FAIL t2_order idx %0d got %h exp %h", i, out1[s+i], 8'(8'h11 + i));
      end
    end
  endtask

  task automatic test_random_ready();
    int s, k;
    do_reset();
    for (int i = 0; i < 1000; i++) push1(8'(i));
    s = nout1;
    k = 0;
    while (nout1 < s + 1000 && k < 6000) begin
      @(negedge clk);
      k++;
      checks++;
      if (level1 > 2'd2) begin errors++; $display("FAIL t3_level cyc %0d got %0d max 2", k, level1); end
      ready1 = 1'($urandom_range(0, 1));
    end
    ready1 = 1'b1;
    checks++;
    if (nout1 - s !== 1000) begin errors++; $display("FAIL t3_count got %0d exp 1000", nout1 - s); end
    for (int i = 0; i < 1000; i++) begin
      checks++;
      if (out1[s+i] !== 8'(i)) begin
        errors++; $display("FAIL t3_seq idx %0d got %h exp %h", i, out1[s+i], 8'(i));
      end
    end
  endtask

  task automatic test_flush();
    int s;
    ready1 = 1'b0;
    flush1 = 1'b0;
    do_reset();
    for (int i = 0; i < 6; i++) push1(8'(8'h40 + i));
    repeat (3) @(negedge clk);
    // One word captured (0x40), one in flight (0x41).
    checks += 2;
    if (level1 !== 2'd2) begin errors++; $display("FAIL t4_pre_level got %0d exp 2", level1); end
    if (valid1 !== 1'b1) begin errors++; $display("FAIL t4_pre_valid got %b exp 1", valid1); end
    flush1 = 1'b1;
    @(negedge clk);
    checks += 3;
    if (valid1 !== 1'b0) begin errors++; $display("FAIL t4_valid got %b exp 0", valid1); end
    if (level1 !== 2'd0) begin errors++; $display("FAIL t4_level got %0d exp 0", level1); end
    if (busy1 !== 1'b1) begin errors++; $display("FAIL t4_busy got %b exp 1", busy1); end
    flush1 = 1'b0;
    ready1 = 1'b1;
    s = nout1;
    wait_words1(s + 4, "t4_resume");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out1[s+i] !== 8'(8'h42 + i)) begin
        errors++; $display("FAIL t4_after idx %0d got %h exp %h", i, out1[s+i], 8'(8'h42 + i));
      end
    end
  endtask

  task automatic test_async_reset();
    int s;
    ready1 = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) push1(8'(8'h50 + i));
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks += 3;
    if (rd_en1 !== 1'b0) begin errors++; $display("FAIL t5_rd_en got %b exp 0", rd_en1); end
    if (valid1 !== 1'b0) begin errors++; $display("FAIL t5_valid got %b exp 0", valid1); end
    if (level1 !== 2'd0) begin errors++; $display("FAIL t5_level got %0d exp 0", level1); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) push1(8'(8'h60 + i));
    s = nout1;
    wait_words1(s + 4, "t5_restart");
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out1[s+i] !== 8'(8'h60 + i)) begin
        errors++; $display("FAIL t5_head idx %0d got %h exp %h", i, out1[s+i], 8'(8'h60 + i));
      end
    end
  endtask

  task automatic test_lat2();
    bit         e_rd [8];
    bit         e_vl [8];
    logic [1:0] e_lv [8];
    logic [7:0] e_dt [8];
    e_rd = '{1, 1, 1, 1, 0, 0, 0, 0};
    e_vl = '{0, 0, 0, 1, 1, 1, 1, 0};
    e_lv = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
    e_dt = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00};
    ready2 = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) push2(8'(8'h11 + i));
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks += 3;
      if (rd_en2 !== e_rd[c]) begin errors++; $display("FAIL t6_rd_en cyc %0d got %b exp %b", c, rd_en2, e_rd[c]); end
      if (valid2 !== e_vl[c]) begin errors++; $display("FAIL t6_valid cyc %0d got %b exp %b", c, valid2, e_vl[c]); end
      if (level2 !== e_lv[c]) begin errors++; $display("FAIL t6_level cyc %0d got %0d exp %0d", c, level2, e_lv[c]); end
      if (e_vl[c]) begin
        checks++;
        if (data2 !== e_dt[c]) begin errors++; $display("FAIL t6_data cyc %0d got %h exp %h", c, data2, e_dt[c]); end
      end
    end
    checks++;
    if (nout2 !== 4) begin errors++; $display("FAIL t6_count got %0d exp 4", nout2); end
  endtask

  initial begin
    rst    = 1'b0;
    ready1 = 1'b1;
    flush1 = 1'b0;
    ready2 = 1'b1;
    flush2 = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_random_ready();
    test_flush();
    test_async_reset();
    test_lat2();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
